// File: rtl/ppm_pkg.sv
// ppm_pkg -- shared definitions for the PPM demodulator.
//   ppm_state_t     : receiver FSM encoding (also exported on the debug port)
//   PREAMBLE_SYMBOL : symbol repeated during the preamble
//   SFD0 / SFD1     : two-symbol start-of-frame delimiter
// Symbol constants are truncated to SYMBOL_BITS by the user; the values
// below assume SYMBOL_BITS >= 4.
package ppm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SCAN     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_SFD      = 3'd3,
        ST_HEADER   = 3'd4,
        ST_DATA     = 3'd5
    } ppm_state_t;

    localparam int PREAMBLE_SYMBOL = 3;
    localparam int SFD0            = 12;
    localparam int SFD1            = 5;

endpackage

// File: rtl/ppmn_correlator.sv
// ppmn_correlator -- combinational peak picker over one symbol of chips.
//   chips           : M chip magnitudes, chip i at bits [i*CHIP_BITS +: CHIP_BITS]
//   threshold       : minimum peak magnitude for a trustworthy symbol
//   symbol          : index of the largest chip (lowest index wins ties)
//   peak            : magnitude of that chip
//   threshold_unmet : peak < threshold
module ppmn_correlator #(
    parameter int SYMBOL_BITS = 4,
    parameter int CHIP_BITS   = 2
) (
    input  logic [(2**SYMBOL_BITS)*CHIP_BITS-1:0] chips,
    input  logic [CHIP_BITS-1:0]                  threshold,
    output logic [SYMBOL_BITS-1:0]                symbol,
    output logic [CHIP_BITS-1:0]                  peak,
    output logic                                  threshold_unmet
);

    localparam int M = 2**SYMBOL_BITS;

    always_comb begin
        symbol = '0;
        peak   = chips[CHIP_BITS-1:0];
        // Strict '>' keeps the earliest chip on ties.
        for (int i = 1; i < M; i++) begin
            if (chips[i*CHIP_BITS +: CHIP_BITS] > peak) begin
                peak   = chips[i*CHIP_BITS +: CHIP_BITS];
                symbol = SYMBOL_BITS'(i);
            end
        end
        threshold_unmet = (peak < threshold);
    end

endmodule

// File: rtl/ppmn_demod.sv
// ppmn_demod -- M-ary PPM receiver for a SPAD detection stream.
//   clk, resetn        : clock, asynchronous active-low reset
//   din                : SPAD detection in this cycle
//   rx_start / abort   : leave IDLE / synchronous return to IDLE
//   corr_threshold     : minimum peak magnitude for a valid symbol
//   dout, dout_erasure : decoded data symbol and its below-threshold flag
//   dout_valid/ready   : output handshake. dout is transferred in a cycle where
//                        both are high; valid then drops unless a new symbol is
//                        loaded in that same cycle.
//   packet_detected    : one-cycle pulse at the end of the header
//   packet_done        : one-cycle pulse at the last data symbol
//   overflow           : sticky, a symbol overwrote one not yet taken
//   packet_len         : length captured from the header
//   fsm_state          : debug view of the receiver state
//   dbg_peak           : debug view of the live correlator peak
module ppmn_demod
    import ppm_pkg::*;
#(
    parameter int SYMBOL_BITS  = 4,
    parameter int CHIP_BITS    = 2,
    parameter int CHIP_CYCLES  = 4,
    parameter int LEN_BITS     = 16,
    parameter int PREAMBLE_MIN = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   din,
    input  logic                   rx_start,
    input  logic                   abort,
    input  logic [CHIP_BITS-1:0]   corr_threshold,
    output logic [SYMBOL_BITS-1:0] dout,
    output logic                   dout_erasure,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   packet_detected,
    output logic                   packet_done,
    output logic                   overflow,
    output logic [LEN_BITS-1:0]    packet_len,
    output ppm_state_t             fsm_state,
    output logic [CHIP_BITS-1:0]   dbg_peak
);

    localparam int M     = 2**SYMBOL_BITS;
    localparam int CYC_W = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;

    localparam logic [CYC_W-1:0]       CYC_LAST  = CYC_W'(CHIP_CYCLES - 1);
    localparam logic [SYMBOL_BITS-1:0] CHIP_LAST = SYMBOL_BITS'(M - 1);
    localparam logic [LEN_BITS-1:0]    HDR_LAST  = LEN_BITS'(LEN_BITS / SYMBOL_BITS - 1);
    localparam logic [7:0]             PRE_MIN   = 8'(PREAMBLE_MIN);
    localparam logic [SYMBOL_BITS-1:0] SYM_PRE   = SYMBOL_BITS'(PREAMBLE_SYMBOL);
    localparam logic [SYMBOL_BITS-1:0] SYM_SFD0  = SYMBOL_BITS'(SFD0);
    localparam logic [SYMBOL_BITS-1:0] SYM_SFD1  = SYMBOL_BITS'(SFD1);

    ppm_state_t               state;
    logic [CYC_W-1:0]         cyc_cnt;
    logic [CHIP_BITS-1:0]     acc;
    logic [SYMBOL_BITS-1:0]   chip_cnt;
    logic [LEN_BITS-1:0]      sym_cnt;
    logic [7:0]               pre_cnt;
    logic [M*CHIP_BITS-1:0]   chip_reg;

    logic                     chip_end;
    logic                     sym_end;
    logic [CHIP_BITS-1:0]     new_chip;
    logic [M*CHIP_BITS-1:0]   chip_next;
    logic [SYMBOL_BITS-1:0]   sym;
    logic [CHIP_BITS-1:0]     peak;
    logic                     unmet;
    logic [LEN_BITS-1:0]      len_next;
    logic [LEN_BITS-1:0]      sym_cnt_inc;

    // The chip completing this cycle includes the current din sample, so the
    // correlator looks at the register as it will be after the shift. That
    // lets a symbol be registered on its own last chip cycle.
    assign chip_end    = (state != ST_IDLE) && (cyc_cnt == CYC_LAST);
    assign sym_end     = chip_end && (chip_cnt == CHIP_LAST);
    assign new_chip    = (din && (acc != '1)) ? acc + 1'b1 : acc;
    // Newest chip enters at index M-1; after M chips index 0 holds the first.
    assign chip_next   = {new_chip, chip_reg[M*CHIP_BITS-1:CHIP_BITS]};
    // Header symbols arrive least significant first: shift in from the top.
    assign len_next    = (packet_len >> SYMBOL_BITS) | (LEN_BITS'(sym) << (LEN_BITS - SYMBOL_BITS));
    assign sym_cnt_inc = sym_cnt + 1'b1;
    assign fsm_state   = state;
    assign dbg_peak    = peak;

    ppmn_correlator #(
        .SYMBOL_BITS (SYMBOL_BITS),
        .CHIP_BITS   (CHIP_BITS)
    ) u_corr (
        .chips           (chip_next),
        .threshold       (corr_threshold),
        .symbol          (sym),
        .peak            (peak),
        .threshold_unmet (unmet)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            cyc_cnt         <= '0;
            acc             <= '0;
            chip_cnt        <= '0;
            sym_cnt         <= '0;
            pre_cnt         <= '0;
            chip_reg        <= '0;
            packet_len      <= '0;
            dout            <= '0;
            dout_erasure    <= 1'b0;
            dout_valid      <= 1'b0;
            packet_detected <= 1'b0;
            packet_done     <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            packet_detected <= 1'b0;
            packet_done     <= 1'b0;
            if (dout_ready) begin
                dout_valid <= 1'b0;
            end

            if (abort) begin
                state      <= ST_IDLE;
                cyc_cnt    <= '0;
                acc        <= '0;
                chip_cnt   <= '0;
                sym_cnt    <= '0;
                pre_cnt    <= '0;
                chip_reg   <= '0;
                dout_valid <= 1'b0;
            end else if (state == ST_IDLE) begin
                cyc_cnt  <= '0;
                acc      <= '0;
                chip_cnt <= '0;
                sym_cnt  <= '0;
                pre_cnt  <= '0;
                chip_reg <= '0;
                if (rx_start) begin
                    overflow <= 1'b0;
                    state    <= ST_SCAN;
                end
            end else begin
                if (chip_end) begin
                    cyc_cnt  <= '0;
                    acc      <= '0;
                    chip_reg <= chip_next;
                    chip_cnt <= (chip_cnt == CHIP_LAST) ? '0 : chip_cnt + 1'b1;
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                    acc     <= new_chip;
                end

                case (state)
                    ST_SCAN: begin
                        // Sliding search: every chip boundary is a candidate alignment.
                        if (chip_end && (sym == SYM_PRE) && !unmet) begin
                            state    <= ST_PREAMBLE;
                            pre_cnt  <= 8'd1;
                            chip_cnt <= '0;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (sym_end) begin
                            if ((sym == SYM_PRE) && !unmet) begin
                                if (pre_cnt != '1) begin
                                    pre_cnt <= pre_cnt + 1'b1;
                                end
                            end else if ((sym == SYM_SFD0) && (pre_cnt >= PRE_MIN)) begin
                                state <= ST_SFD;
                            end else begin
                                state <= ST_SCAN;
                            end
                        end
                    end
                    ST_SFD: begin
                        if (sym_end) begin
                            sym_cnt <= '0;
                            state   <= (sym == SYM_SFD1) ? ST_HEADER : ST_SCAN;
                        end
                    end
                    ST_HEADER: begin
                        if (sym_end) begin
                            packet_len <= len_next;
                            if (sym_cnt == HDR_LAST) begin
                                packet_detected <= 1'b1;
                                sym_cnt         <= '0;
                                if (len_next == '0) begin
                                    packet_done <= 1'b1;
                                    state       <= ST_IDLE;
                                end else begin
                                    state <= ST_DATA;
                                end
                            end else begin
                                sym_cnt <= sym_cnt_inc;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sym_end) begin
                            dout         <= sym;
                            dout_erasure <= unmet;
                            dout_valid   <= 1'b1;
                            if (dout_valid && !dout_ready) begin
                                overflow <= 1'b1;
                            end
                            sym_cnt <= sym_cnt_inc;
                            if (sym_cnt_inc == packet_len) begin
                                packet_done <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ppmn_demod.sv
// tb_ppmn_demod -- self-checking bench for ppmn_demod with default parameters.
// Stimulus is built chip by chip; the expected symbol of each data symbol is
// derived from the chip hit counts the bench itself generated.
module tb_ppmn_demod;
    import ppm_pkg::*;

    localparam int SB   = 4;
    localparam int CB   = 2;
    localparam int CC   = 4;
    localparam int LB   = 16;
    localparam int M    = 1 << SB;
    localparam int HDR  = LB / SB;
    localparam int CMAX = (1 << CB) - 1;

    // ---------------- clock / reset / signals ----------------
    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          din = 1'b0;
    logic          rx_start = 1'b0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b1;
    logic [CB-1:0] corr_threshold = 2'd1;
    logic [SB-1:0] dout;
    logic          dout_erasure;
    logic          dout_valid;
    logic          packet_detected;
    logic          packet_done;
    logic          overflow;
    logic [LB-1:0] packet_len;
    ppm_state_t    fsm_state;
    logic [CB-1:0] dbg_peak;

    always #5 clk = ~clk;

    ppmn_demod dut (
        .clk             (clk),
        .resetn          (resetn),
        .din             (din),
        .rx_start        (rx_start),
        .abort           (abort),
        .corr_threshold  (corr_threshold),
        .dout            (dout),
        .dout_erasure    (dout_erasure),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .packet_detected (packet_detected),
        .packet_done     (packet_done),
        .overflow        (overflow),
        .packet_len      (packet_len),
        .fsm_state       (fsm_state),
        .dbg_peak        (dbg_peak)
    );

    int checks = 0;
    int errors = 0;
    int det_seen = 0;
    int done_seen = 0;
    int det_exp = 0;
    int done_exp = 0;
    logic [SB:0] exp_q[$];   // {erasure, symbol}
    int chips_buf[M];        // hit count per chip of the symbol being sent

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int sat(input int x);
        return (x > CMAX) ? CMAX : x;
    endfunction

    // Most energetic chip (earliest on a tie) is the symbol; erasure when the
    // winning magnitude falls short of the threshold.
    function automatic logic [SB:0] model_symbol(input int thr);
        int best = 0;
        logic er;
        logic [SB-1:0] s;
        for (int i = 1; i < M; i++)
            if (sat(chips_buf[i]) > sat(chips_buf[best])) best = i;
        er = (sat(chips_buf[best]) < thr);
        s  = SB'(best);
        return {er, s};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (resetn) begin
            if (packet_detected) det_seen++;
            if (packet_done) done_seen++;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dout: got %0h expected no transfer at %0t",
                             {dout_erasure, dout}, $time);
                end else begin
                    check("dout_symbol", {dout_erasure, dout}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input logic d);
        din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_chip(input int hits);
        for (int c = 0; c < CC; c++) tick(c < hits);
    endtask

    task automatic send_buf();
        for (int i = 0; i < M; i++) send_chip(chips_buf[i]);
    endtask

    task automatic send_clean(input int s);
        for (int i = 0; i < M; i++) chips_buf[i] = 0;
        chips_buf[s] = CC;
        send_buf();
    endtask

    task automatic send_data(input int s, input bit blank, input bit noise, input bit push,
                             output logic [SB:0] e);
        for (int i = 0; i < M; i++) chips_buf[i] = noise ? $urandom_range(0, 1) : 0;
        if (!blank) chips_buf[s] = noise ? $urandom_range(0, CC) : CC;
        e = model_symbol(int'(corr_threshold));
        if (push) exp_q.push_back(e);
        send_buf();
        check("latency_valid", dout_valid, 1);
    endtask

    task automatic start_rx();
        rx_start = 1'b1;
        tick(1'b0);
        rx_start = 1'b0;
        check("overflow_clear_on_start", overflow, 0);
        check("state_scan", fsm_state, ST_SCAN);
    endtask

    task automatic prologue(input int npre, input logic [LB-1:0] len);
        start_rx();
        repeat (M + $urandom_range(0, 8)) send_chip(0);
        for (int p = 0; p < npre; p++) send_clean(PREAMBLE_SYMBOL);
        send_clean(SFD0);
        send_clean(SFD1);
        for (int k = 0; k < HDR; k++) send_clean(int'(len[k*SB +: SB]));
        check("pkt_det_pulse", packet_detected, 1);
        check("packet_len", packet_len, len);
        det_exp++;
    endtask

    task automatic end_of_frame();
        check("pkt_done_pulse", packet_done, 1);
        check("idle_after_frame", fsm_state, ST_IDLE);
        done_exp++;
        tick(1'b0);
        tick(1'b0);
    endtask

    // ---------------- test sequence ----------------
    logic [SB:0] e;
    logic [SB:0] e2;
    int len_r;

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_valid", dout_valid, 0);
        check("rst_dout", {dout_erasure, dout}, 0);
        check("rst_len", packet_len, 0);
        check("rst_overflow", overflow, 0);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) tick($urandom_range(0, 1));
        check("idle_until_start", fsm_state, ST_IDLE);

        // Nominal frame: len 3, data 5, A, F.
        corr_threshold = 2'd1;
        prologue(3, 16'd3);
        send_data(5, 0, 0, 1, e);
        send_data(10, 0, 0, 1, e);
        send_data(15, 0, 0, 1, e);
        end_of_frame();

        // One preamble then SFD0: too short, back to SCAN.
        start_rx();
        repeat (M) send_chip(0);
        send_clean(PREAMBLE_SYMBOL);
        check("state_preamble", fsm_state, ST_PREAMBLE);
        send_clean(SFD0);
        check("short_preamble_scan", fsm_state, ST_SCAN);
        check("short_no_detect", packet_detected, 0);
        abort = 1'b1;
        tick(1'b0);
        abort = 1'b0;
        check("abort_idle", fsm_state, ST_IDLE);

        // Blank data symbol: index 0, erasure.
        prologue(2, 16'd1);
        send_data(0, 1, 0, 1, e);
        check("blank_dout", dout, 0);
        check("blank_erasure", dout_erasure, 1);
        end_of_frame();

        // Two data symbols with the sink stalled.
        prologue(2, 16'd2);
        dout_ready = 1'b0;
        send_data($urandom_range(0, M - 1), 0, 0, 0, e);
        check("no_overflow_yet", overflow, 0);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e2);
        check("overflow_set", overflow, 1);
        check("overflow_dout", {dout_erasure, dout}, e2);
        end_of_frame();
        check("overflow_sticky", overflow, 1);
        dout_ready = 1'b1;
        tick(1'b0);
        tick(1'b0);

        // Zero-length packet.
        prologue(2, 16'd0);
        end_of_frame();
        check("zero_len_no_valid", dout_valid, 0);

        // Abort mid-DATA.
        prologue(3, 16'd4);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e);
        send_chip(1);
        send_chip(0);
        abort = 1'b1;
        tick(1'b0);
        abort = 1'b0;
        check("abort_data_idle", fsm_state, ST_IDLE);
        check("abort_valid_clear", dout_valid, 0);
        check("abort_len_kept", packet_len, 4);
        tick(1'b0);

        // Reset mid-DATA.
        prologue(2, 16'd4);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e);
        send_chip(CC);
        resetn = 1'b0;
        #1;
        check("midrst_state", fsm_state, ST_IDLE);
        check("midrst_valid", dout_valid, 0);
        check("midrst_len", packet_len, 0);
        check("midrst_dout", {dout_erasure, dout}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(1'b0);
        check("after_rst_idle", fsm_state, ST_IDLE);

        // Clean frame after reset.
        prologue(2, 16'd2);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e);
        send_data($urandom_range(0, M - 1), 0, 0, 1, e);
        end_of_frame();

        // Randomised frames with noisy data chips and varying threshold.
        for (int f = 0; f < 6; f++) begin
            corr_threshold = CB'($urandom_range(1, CMAX));
            len_r = $urandom_range(1, 4);
            prologue($urandom_range(2, 4), LB'(len_r));
            for (int k = 0; k < len_r; k++)
                send_data($urandom_range(0, M - 1), 0, 1, 1, e);
            end_of_frame();
        end

        repeat (4) tick(1'b0);
        check("det_count", det_seen, det_exp);
        check("done_count", done_seen, done_exp);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppmn_demod.md
PPMN_DEMOD -- requirements
Module: ppmn_demod

Interface
REQ-001 SHALL have parameter SYMBOL_BITS, default 4: log2 of PPM order; M = 2^SYMBOL_BITS chips per symbol.
REQ-002 SHALL have parameter CHIP_BITS, default 2: width of the saturating chip magnitude.
REQ-003 SHALL have parameter CHIP_CYCLES, default 4: clk cycles per chip.
REQ-004 SHALL have parameter LEN_BITS, default 16: length field width, a multiple of SYMBOL_BITS.
REQ-005 SHALL have parameter PREAMBLE_MIN, default 2: minimum consecutive preamble symbols before SFD is accepted.
REQ-006 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have ports din (input, 1: SPAD detection this cycle), rx_start (input, 1: leave IDLE) and abort (input, 1: synchronous return to IDLE).
REQ-009 SHALL have port corr_threshold, input, CHIP_BITS: minimum peak magnitude for a valid symbol.
REQ-010 SHALL have port dout, output, SYMBOL_BITS (decoded data symbol), and dout_erasure, output, 1 (that symbol's peak was below threshold).
REQ-011 SHALL have ports dout_valid (output, 1) and dout_ready (input, 1): valid/ready handshake.
REQ-012 SHALL have ports packet_detected (output, 1: one-cycle pulse at header end), packet_done (output, 1: one-cycle pulse at last data symbol), overflow (output, 1: sticky) and packet_len (output, LEN_BITS: captured length).

Function
REQ-013 Chip accumulator SHALL count din=1 cycles over CHIP_CYCLES cycles, saturating at 2^CHIP_BITS-1; the completed chip SHALL shift into an M-deep chip register at each chip boundary.
REQ-014 Correlator SHALL output the index of the maximum-magnitude chip (lowest index wins ties), the peak value, and threshold_unmet = peak < corr_threshold; it SHALL be combinational, evaluated at chip boundaries.
REQ-015 States: IDLE, SCAN, PREAMBLE, SFD, HEADER, DATA.
REQ-016 IDLE: accumulator and counters held at zero; rx_start=1 -> SCAN next cycle.
REQ-017 SCAN: at every chip boundary (sliding, chip-granular alignment), symbol==PREAMBLE_SYMBOL and threshold met -> PREAMBLE with preamble count=1 and the symbol chip counter aligned to that boundary.
REQ-018 PREAMBLE: at each symbol boundary, a preamble symbol with threshold met increments the count (saturating); SFD0 with count>=PREAMBLE_MIN -> SFD; anything else -> SCAN.
REQ-019 SFD: SFD1 at symbol boundary -> HEADER; else -> SCAN.
REQ-020 HEADER: LEN_BITS/SYMBOL_BITS symbols loaded least-significant symbol first into packet_len; after the last one: packet_detected pulses for one cycle; len==0 -> IDLE with packet_done pulse; else -> DATA.
REQ-021 DATA: each symbol boundary SHALL load dout/dout_erasure and set dout_valid; after packet_len symbols: packet_done pulses and state -> IDLE.
REQ-022 dout_valid SHALL stay high until a cycle with dout_ready=1, then clear, unless a new symbol is loaded in that same cycle.
REQ-023 A new symbol arriving while dout_valid=1 and dout_ready=0 SHALL overwrite dout and set overflow; overflow SHALL clear only on reset or rx_start in IDLE.
REQ-024 abort=1 SHALL force IDLE next cycle from any state and clear counters and accumulator; dout_valid SHALL clear; overflow and packet_len are retained; abort overrides all other transitions.
REQ-025 Latency: dout SHALL be valid the cycle after the last chip cycle of its symbol.
REQ-026 All counters SHALL wrap only under state control; the symbol counter SHALL be LEN_BITS wide, compared for equality with packet_len.

Reset
REQ-027 Asserting resetn low SHALL immediately set state=IDLE; all counters, accumulator, chip register, packet_len, dout, dout_erasure, dout_valid, packet_detected, packet_done and overflow SHALL be 0, including mid-packet.
REQ-028 After resetn is released, the block SHALL remain in IDLE until rx_start.

Structure
REQ-029 Shared package ppm_pkg SHALL hold state encoding, PREAMBLE_SYMBOL, SFD0 and SFD1 constants.
REQ-030 Correlator SHALL be sub-module ppmn_correlator, parametrised by SYMBOL_BITS and CHIP_BITS.

Verification
REQ-031 Defaults; 3 preambles, SFD0, SFD1, header len=3, data 5,A,F, dout_ready=1 -> packet_detected once; dout 5,A,F; packet_done once; then IDLE.
REQ-032 Single preamble then SFD0 (PREAMBLE_MIN=2) -> return to SCAN; no packet_detected.
REQ-033 Data symbol with all chip counts 0, threshold=1 -> dout=0, dout_erasure=1.
REQ-034 dout_ready=0 across 2 data symbols -> overflow=1, dout holds the second symbol.
REQ-035 header len=0 -> packet_detected and packet_done, no dout_valid.
REQ-036 abort, then resetn low, mid-DATA -> IDLE; dout_valid=0; next rx_start frame decodes correctly.
